// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencing controller: arbitrates halt, jump, branch and load-use
// requests into PC-unit selects, pause and a one-cycle wrong-path flush.
module fetch_seq_ctrl #(
   parameter logic [31:0] END_PC    = 32'h0000_306c,
   parameter int          STALL_LEN = 1
) (
   input  logic        clk,
   input  logic        PcReSet,
   input  logic [31:0] pc,
   input  logic        load_use,
   input  logic        branch_taken,
   input  logic [31:0] branch_off,
   input  logic        jump_req,
   input  logic [25:0] jump_target,
   input  logic        halt_req,
   input  logic        resume,
   output logic        pause,
   output logic        pc_sel,
   output logic [31:0] adress,
   output logic        jump,
   output logic [25:0] jumpaddr,
   output logic        flush,
   output logic [1:0]  state,
   output logic [15:0] stall_count,
   output logic [15:0] redirect_count
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      REDIR = 2'd2,
      HALT  = 2'd3
   } st_t;

   st_t        cur_st, nxt_st;
   logic [3:0] stall_cnt;
   logic       halt_c;
   logic       ld_stall;
   logic       redir_ev;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign halt_c   = halt_req || (pc >= END_PC);
   assign ld_stall = (cur_st == RUN) && !halt_c && !jump_req && !branch_taken && load_use;
   assign redir_ev = (cur_st == RUN) && !halt_c && (jump_req || branch_taken);
   assign state    = cur_st;

   // flush is registered so it is high exactly while the FSM sits in REDIR
   always_ff @(posedge clk or posedge PcReSet) begin
      if (PcReSet) begin
         cur_st <= RUN;
         flush  <= 1'b0;
      end else begin
         cur_st <= nxt_st;
         flush  <= (nxt_st == REDIR);
      end
   end

   always_comb begin
      nxt_st = cur_st;
      case (cur_st)
         RUN: begin
            if (halt_c)
               nxt_st = HALT;
            else if (jump_req || branch_taken)
               nxt_st = REDIR;
            else if (load_use)
               nxt_st = (STALL_LEN > 1) ? STALL : RUN;
         end
         STALL: begin
            // the RUN cycle that raised the stall already paused once
            if (stall_cnt <= 4'd1)
               nxt_st = RUN;
         end
         REDIR:   nxt_st = RUN;
         HALT: begin
            if (resume && !halt_req)
               nxt_st = RUN;
         end
         default: nxt_st = RUN;
      endcase
   end

   always_comb begin
      pause    = 1'b0;
      pc_sel   = 1'b0;
      jump     = 1'b0;
      adress   = 32'd0;
      jumpaddr = 26'd0;
      case (cur_st)
         RUN: begin
            if (halt_c)
               pause = 1'b1;
            else if (jump_req) begin
               jump     = 1'b1;
               jumpaddr = jump_target;
            end else if (branch_taken) begin
               pc_sel = 1'b1;
               adress = branch_off;
            end else if (load_use)
               pause = 1'b1;
         end
         STALL:   pause = 1'b1;
         HALT:    pause = 1'b1;
         default: pause = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge PcReSet) begin
      if (PcReSet) begin
         stall_cnt      <= 4'd0;
         stall_count    <= 16'd0;
         redirect_count <= 16'd0;
      end else begin
         if (ld_stall)
            stall_cnt <= 4'(STALL_LEN - 1);
         else if (cur_st == STALL && stall_cnt != 4'd0)
            stall_cnt <= stall_cnt - 4'd1;
         if (ld_stall || cur_st == STALL)
            stall_count <= sat_inc(stall_count);
         if (redir_ev)
            redirect_count <= sat_inc(redirect_count);
      end
   end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl with STALL_LEN=3: reset, idle run,
// stall length, jump/branch priority, stall masking, halt/resume, async reset.
module tb_fetch_seq_ctrl;

   logic        clk = 1'b0;
   logic        PcReSet;
   logic [31:0] pc;
   logic        load_use, branch_taken, jump_req, halt_req, resume;
   logic [31:0] branch_off;
   logic [25:0] jump_target;
   logic        pause, pc_sel, jump, flush;
   logic [31:0] adress;
   logic [25:0] jumpaddr;
   logic [1:0]  state;
   logic [15:0] stall_count, redirect_count;

   int nvec = 0;
   int nerr = 0;

   fetch_seq_ctrl #(.END_PC(32'h0000_306c), .STALL_LEN(3)) dut (
      .clk(clk), .PcReSet(PcReSet), .pc(pc), .load_use(load_use),
      .branch_taken(branch_taken), .branch_off(branch_off),
      .jump_req(jump_req), .jump_target(jump_target), .halt_req(halt_req),
      .resume(resume), .pause(pause), .pc_sel(pc_sel), .adress(adress),
      .jump(jump), .jumpaddr(jumpaddr), .flush(flush), .state(state),
      .stall_count(stall_count), .redirect_count(redirect_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int np, ns;
      PcReSet = 1'b1; pc = 32'h3000; load_use = 0; branch_taken = 0;
      jump_req = 0; halt_req = 0; resume = 0; branch_off = 0; jump_target = 0;
      #2;
      chk("rst_state", 32'(state), 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_stallcnt", 32'(stall_count), 0);
      chk("rst_redircnt", 32'(redirect_count), 0);
      #10 PcReSet = 1'b0;

      // idle run after reset release
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk("idle_pause", 32'(pause), 0);
         chk("idle_pcsel", 32'(pc_sel), 0);
         chk("idle_jump", 32'(jump), 0);
         chk("idle_state", 32'(state), 0);
      end

      // single load-use pulse
      tick();
      pc = 32'h3010; load_use = 1;
      np = 0; ns = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         np += int'(pause);
         ns += int'(state == 2'd1);
         tick();
         load_use = 0;
      end
      chk("stall_pauses", 32'(np), 3);
      chk("stall_states", 32'(ns), 2);
      chk("stall_count", 32'(stall_count), 3);
      chk("stall_redir", 32'(redirect_count), 0);

      // jump and branch together: jump wins
      branch_taken = 1; jump_req = 1; jump_target = 26'h0C08; branch_off = 32'h5;
      #1;
      chk("jb_jump", 32'(jump), 1);
      chk("jb_jaddr", 32'(jumpaddr), 32'h0C08);
      chk("jb_pcsel", 32'(pc_sel), 0);
      chk("jb_adress", adress, 0);
      chk("jb_flush_pre", 32'(flush), 0);
      tick();
      jump_req = 0; jump_target = 0;
      #1;
      chk("redir_flush", 32'(flush), 1);
      chk("redir_state", 32'(state), 2);
      chk("redir_cnt", 32'(redirect_count), 1);
      chk("redir_pause", 32'(pause), 0);
      chk("redir_ign_pcsel", 32'(pc_sel), 0);
      tick();
      branch_taken = 0;
      #1;
      chk("post_redir_state", 32'(state), 0);
      chk("post_redir_flush", 32'(flush), 0);
      chk("post_redir_cnt", 32'(redirect_count), 1);

      // branch alone
      branch_taken = 1; branch_off = 32'hFFFF_FFF0;
      #1;
      chk("br_pcsel", 32'(pc_sel), 1);
      chk("br_adress", adress, 32'hFFFF_FFF0);
      chk("br_jump", 32'(jump), 0);
      tick();
      branch_taken = 0;
      #1;
      chk("br_cnt", 32'(redirect_count), 2);
      tick();
      chk("br_back_run", 32'(state), 0);

      // redirects are masked during a stall
      load_use = 1;
      tick();
      load_use = 0; branch_taken = 1; jump_req = 1;
      #1;
      chk("stl_state", 32'(state), 1);
      chk("stl_pcsel", 32'(pc_sel), 0);
      chk("stl_jump", 32'(jump), 0);
      chk("stl_pause", 32'(pause), 1);
      tick();
      branch_taken = 0; jump_req = 0;
      tick();
      chk("stl_exit", 32'(state), 0);
      chk("stl_redircnt", 32'(redirect_count), 2);
      chk("stl_stallcnt", 32'(stall_count), 6);

      // auto-halt at END_PC beats a jump
      pc = 32'h306c; jump_req = 1;
      #1;
      chk("halt_pause", 32'(pause), 1);
      chk("halt_nojump", 32'(jump), 0);
      tick();
      jump_req = 0; pc = 32'h3000;
      chk("halt_state", 32'(state), 3);
      halt_req = 1; resume = 1;
      tick();
      chk("halt_hold", 32'(state), 3);
      chk("halt_hold_pause", 32'(pause), 1);
      halt_req = 0;
      tick();
      resume = 0;
      chk("halt_resume", 32'(state), 0);
      chk("halt_redircnt", 32'(redirect_count), 2);

      // async reset in the middle of a redirect
      jump_req = 1; jump_target = 26'h0123;
      tick();
      jump_req = 0;
      chk("ar_flush_pre", 32'(flush), 1);
      #2 PcReSet = 1'b1;
      #1;
      chk("ar_flush", 32'(flush), 0);
      chk("ar_state", 32'(state), 0);
      chk("ar_redircnt", 32'(redirect_count), 0);
      chk("ar_stallcnt", 32'(stall_count), 0);
      #5 PcReSet = 1'b0;
      tick();
      chk("ar_post_state", 32'(state), 0);
      chk("ar_post_flush", 32'(flush), 0);
      chk("ar_post_pause", 32'(pause), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/fetch_seq_ctrl.md
FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

Interface
REQ-001 Parameter END_PC, default 32'h0000_306c: PC value at or above which fetch auto-halts.
REQ-002 Parameter STALL_LEN, default 1, legal range 1..15: pause cycles per load-use stall.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 PcReSet  input  1  reset, asynchronous, active-high.
REQ-005 pc  input  32  current PC value from the PC unit.
REQ-006 load_use  input  1  load-use hazard request from decode.
REQ-007 branch_taken  input  1  conditional branch resolved taken.
REQ-008 branch_off  input  32  branch word offset.
REQ-009 jump_req  input  1  unconditional jump request.
REQ-010 jump_target  input  26  jump word index.
REQ-011 halt_req  input  1  external halt request.
REQ-012 resume  input  1  leave HALT.
REQ-013 pause  output  1  freezes PC increment.
REQ-014 pc_sel  output  1  selects PC+offset update.
REQ-015 adress  output  32  offset to PC unit.
REQ-016 jump  output  1  selects jump update.
REQ-017 jumpaddr  output  26  jump index to PC unit.
REQ-018 flush  output  1  registered; kills the wrong-path instruction.
REQ-019 state  output  2  FSM state: 0 RUN, 1 STALL, 2 REDIRECT, 3 HALT.
REQ-020 stall_count  output  16  saturating count of cycles with pause=1 in STALL.
REQ-021 redirect_count  output  16  saturating count of issued branch/jump redirects.

Function
REQ-022 pause, pc_sel, jump, adress and jumpaddr shall be combinational from state and inputs; the PC unit samples them on the same clk edge.
REQ-023 adress shall equal branch_off and jumpaddr shall equal jump_target when the respective select is 1; otherwise both shall be 0.
REQ-024 In RUN, request priority shall be: halt_req or pc>=END_PC (unsigned) > jump_req > branch_taken > load_use.
REQ-025 RUN + halt condition: pause=1, no selects asserted; next state HALT.
REQ-026 RUN + jump_req: jump=1, pc_sel=0, pause=0; next state REDIRECT; redirect_count increments.
REQ-027 RUN + branch_taken (no jump): pc_sel=1, pause=0; next state REDIRECT; redirect_count increments.
REQ-028 RUN + load_use only: pause=1; stall counter loads STALL_LEN-1; next state STALL if STALL_LEN>1, else RUN.
REQ-029 STALL: pause=1; pc_sel=jump=0; branch/jump requests ignored; counter decrements each cycle; exit to RUN on the cycle the counter is 0.
REQ-030 REDIRECT lasts exactly one cycle: flush=1, pause=0, all requests ignored; next state RUN.
REQ-031 flush shall be 0 in every state other than REDIRECT.
REQ-032 HALT: pause=1, selects 0; exit to RUN only on resume=1 with halt_req=0; resume while halt_req=1 shall stay in HALT.
REQ-033 stall_count increments in each STALL cycle and in the RUN cycle that enters a stall; both counters stop at 16'hFFFF.
REQ-034 No cycle shall assert pc_sel and jump together.

Reset
REQ-035 PcReSet=1 shall immediately force state=RUN, flush=0, stall counter=0, stall_count=0, redirect_count=0, independent of clk.
REQ-036 Reset asserted mid-STALL or mid-REDIRECT shall abandon the operation; after release the first cycle is RUN with no pending request.

Verification
REQ-037 Reset release, pc=32'h3000, no requests -> pause=0, pc_sel=0, jump=0, state=0 every cycle.
REQ-038 STALL_LEN=3, load_use one cycle at pc=32'h3010 -> pause=1 for exactly 3 cycles, stall_count=3, state 1 for 2 cycles.
REQ-039 branch_taken=1, jump_req=1, jump_target=26'h0C08 same cycle -> jump=1, jumpaddr=26'h0C08, pc_sel=0, flush=1 next cycle, redirect_count=1.
REQ-040 branch_taken during STALL -> pc_sel stays 0, redirect_count unchanged.
REQ-041 pc=32'h306c -> state HALT, pause=1; resume with halt_req=1 -> stays HALT; resume with halt_req=0 -> RUN.
REQ-042 PcReSet pulse during REDIRECT -> flush=0 and counters=0 immediately, without waiting for a clk edge.
